iterative_alu: RTL

Multi-cycle execute unit for the RV32I five-stage pipeline. It is the consumer end of the 4-bit `alu_select` code produced by ALU control. It accepts one operation at a time over a valid/ready handshake. Logic and arithmetic ops finish in one cycle; shifts are performed one bit per cycle to save area. Results and branch-compare flags are held until the EX/MEM side accepts them, and the pipeline stalls on `in_ready` low.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_shift_step.sv | 20 ++
 rtl/iterative_alu.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control encoder and the iterative_alu decoder.
// Keeping the operation codes here stops the two ends from drifting apart.
package alu_pkg;

  localparam int ALU_SEL_W = 4;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_SEL_W-1:0] ALU_SLL  = 4'b0010;
  localparam logic [ALU_SEL_W-1:0] ALU_SRL  = 4'b0011;
  localparam logic [ALU_SEL_W-1:0] ALU_SRA  = 4'b0100;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 4'b0101;
  localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_SEL_W-1:0] ALU_AND  = 4'b0111;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT  = 4'b1000;
  localparam logic [ALU_SEL_W-1:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input logic [ALU_SEL_W-1:0] sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift of the accumulator; left fills with zero, right fills with
// zero or the sign bit depending on the arithmetic flag.
module alu_shift_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] acc,
  input  logic            shift_left,
  input  logic            arith,
  output logic [XLEN-1:0] shifted
);

  always_comb begin
    if (shift_left) begin
      shifted = {acc[XLEN-2:0], 1'b0};
    end else begin
      shifted = {arith & acc[XLEN-1], acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/iterative_alu.sv
// Multi-cycle RV32I execute unit: single-cycle logic/arithmetic, bit-serial
// shifts, results and compare flags held until the consumer accepts them.
module iterative_alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ALU_SEL_W-1:0] alu_select,
  input  logic [XLEN-1:0]      op_a,
  input  logic [XLEN-1:0]      op_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      result,
  output logic                 eq,
  output logic                 lt,
  output logic                 ltu,
  output logic                 illegal
);

  localparam int SHAMT_W = $clog2(XLEN);

  alu_state_e          state_q, state_d;
  logic [SHAMT_W-1:0]  count_q;
  logic                shift_left_q;
  logic                shift_arith_q;

  logic [SHAMT_W-1:0]  shamt;
  logic                accept;
  logic                start_shift;
  logic                cmp_eq, cmp_lt, cmp_ltu;
  logic [XLEN-1:0]     alu_value;
  logic                illegal_op;
  logic [XLEN-1:0]     shifted;

  assign shamt       = op_b[SHAMT_W-1:0];
  assign accept      = (state_q == ST_IDLE) && in_valid && !flush;
  assign start_shift = is_shift(alu_select) && (shamt != '0);

  assign cmp_eq  = (op_a == op_b);
  assign cmp_lt  = ($signed(op_a) < $signed(op_b));
  assign cmp_ltu = (op_a < op_b);

  // Single-cycle result; a zero-amount shift simply passes op_a through.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    alu_value  = '0;
    illegal_op = 1'b0;
    case (alu_select)
      ALU_ADD:                   alu_value = op_a + op_b;
      ALU_SUB:                   alu_value = op_a - op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: alu_value = op_a;
      ALU_XOR:                   alu_value = op_a ^ op_b;
      ALU_OR:                    alu_value = op_a | op_b;
      ALU_AND:                   alu_value = op_a & op_b;
      ALU_SLT:                   alu_value = {{(XLEN-1){1'b0}}, cmp_lt};
      ALU_SLTU:                  alu_value = {{(XLEN-1){1'b0}}, cmp_ltu};
      default:                   illegal_op = 1'b1;
    endcase
  end

  alu_shift_step #(.XLEN(XLEN)) u_shift_step (
    .acc        (result),
    .shift_left (shift_left_q),
    .arith      (shift_arith_q),
    .shifted    (shifted)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = start_shift ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (count_q == SHAMT_W'(1)) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // The result register doubles as the shift accumulator; out_valid is low
  // while it is being shifted, so the intermediate values are never consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      result        <= '0;
      eq            <= 1'b0;
      lt            <= 1'b0;
      ltu           <= 1'b0;
      illegal       <= 1'b0;
      count_q       <= '0;
      shift_left_q  <= 1'b0;
      shift_arith_q <= 1'b0;
    end else if (flush) begin
      count_q <= '0;
    end else if (accept) begin
      eq            <= cmp_eq;
      lt            <= cmp_lt;
      ltu           <= cmp_ltu;
      illegal       <= illegal_op;
      shift_left_q  <= (alu_select == ALU_SLL);
      shift_arith_q <= (alu_select == ALU_SRA);
      if (start_shift) begin
        result  <= op_a;
        count_q <= shamt;
      end else begin
        result  <= alu_value;
        count_q <= '0;
      end
    end else if (state_q == ST_SHIFT) begin
      result  <= shifted;
      count_q <= count_q - SHAMT_W'(1);
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

endmodule
